mc_pwm: RTL and testbench

PWM generator that sits directly downstream of the 5-bit free-running counter `mc_cnt`. It samples the counter's `io_out` value every cycle and compares it against a double-buffered duty value to drive a registered PWM output. New duty values arrive over a valid/ready handshake and take effect only at a period boundary. A per-period count of high cycles is reported for monitoring.

---
 rtl/mc_pwm.sv | 80 ++++++++
 tb/tb_mc_pwm.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/mc_pwm.sv
// mc_pwm: registered PWM generator driven by an external free-running counter.
// Duty values arrive over valid/ready, are double-buffered and take effect at a
// period boundary. A saturating per-period high-cycle count is reported.
module mc_pwm #(
    parameter int unsigned W      = 5,
    parameter bit          INVERT = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] io_cnt,
    input  logic [W-1:0] io_duty,
    input  logic         io_duty_valid,
    output logic         io_duty_ready,
    output logic         io_pwm,
    output logic         io_boundary,
    output logic [W:0]   io_high_cycles,
    output logic         io_stat_valid
);

    logic [W-1:0] prev_cnt;
    logic [W-1:0] active;
    logic [W-1:0] pending;
    logic         pending_v;
    logic [W:0]   acc;

    logic         bnd;
    logic [W-1:0] eff;
    logic         hit;
    logic [W:0]   acc_inc;

    // Boundary detection, effective duty selection, compare and saturating increment
    always_comb begin
        bnd     = (io_cnt == '0) || (io_cnt < prev_cnt);
        eff     = (bnd && pending_v) ? pending : active;
        hit     = io_cnt < eff;
        acc_inc = (acc == '1) ? acc : acc + {{W{1'b0}}, hit};
    end

    // Ready depends only on the buffer-occupied flag
    assign io_duty_ready = !pending_v;

    // State and registered outputs; synchronous reset has priority
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_cnt       <= '0;
            active         <= '0;
            pending        <= '0;
            pending_v      <= 1'b0;
            acc            <= '0;
            io_pwm         <= INVERT;
            io_boundary    <= 1'b0;
            io_high_cycles <= '0;
            io_stat_valid  <= 1'b0;
        end else begin
            prev_cnt      <= io_cnt;
            io_pwm        <= hit ^ INVERT;
            io_boundary   <= bnd;
            io_stat_valid <= bnd;

            if (bnd) begin
                io_high_cycles <= acc;
                acc            <= {{W{1'b0}}, hit};
            end else begin
                acc <= acc_inc;
            end

            // A buffered duty is consumed at a boundary; a transfer can only
            // happen while the buffer is empty, so the two never collide. A
            // transfer on a boundary with an empty buffer just fills it.
            if (bnd && pending_v) begin
                active    <= pending;
                pending_v <= 1'b0;
            end else if (io_duty_valid && !pending_v) begin
                pending   <= io_duty;
                pending_v <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mc_pwm.sv
// tb_mc_pwm: directed testbench for mc_pwm (normal and inverted instances).
module tb_mc_pwm;

    localparam int W = 5;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] io_cnt;
    logic [W-1:0] io_duty;
    logic         io_duty_valid;

    logic         ready_n, pwm_n, bnd_n, sv_n;
    logic [W:0]   hc_n;
    logic         ready_i, pwm_i, bnd_i, sv_i;
    logic [W:0]   hc_i;

    int n_cmp = 0;
    int n_err = 0;

    int  req_q[$];
    bit  exp_ready;

    mc_pwm #(.W(W), .INVERT(1'b0)) u_dut (
        .clk(clk), .reset(reset), .io_cnt(io_cnt), .io_duty(io_duty),
        .io_duty_valid(io_duty_valid), .io_duty_ready(ready_n), .io_pwm(pwm_n),
        .io_boundary(bnd_n), .io_high_cycles(hc_n), .io_stat_valid(sv_n)
    );

    mc_pwm #(.W(W), .INVERT(1'b1)) u_inv (
        .clk(clk), .reset(reset), .io_cnt(io_cnt), .io_duty(io_duty),
        .io_duty_valid(io_duty_valid), .io_duty_ready(ready_i), .io_pwm(pwm_i),
        .io_boundary(bnd_i), .io_high_cycles(hc_i), .io_stat_valid(sv_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One counter sample: drive, clock, then check the registered result.
    // hc < 0 skips the statistics value check.
    task automatic step(input int c, input bit bnd, input bit hit, input int hc);
        bit take;
        bit nxt;
        io_cnt = c[W-1:0];
        if (req_q.size() > 0) begin
            io_duty_valid = 1'b1;
            io_duty       = req_q[0][W-1:0];
        end else begin
            io_duty_valid = 1'b0;
        end
        take = io_duty_valid && exp_ready;
        nxt  = exp_ready;
        if (bnd && !exp_ready) nxt = 1'b1;
        if (take)              nxt = 1'b0;
        @(posedge clk);
        #1;
        chk($sformatf("pwm c=%0d", c), pwm_n, hit);
        chk($sformatf("pwm_inv c=%0d", c), pwm_i, !hit);
        chk($sformatf("boundary c=%0d", c), bnd_n, bnd);
        chk($sformatf("stat_valid c=%0d", c), sv_n, bnd);
        chk($sformatf("ready c=%0d", c), ready_n, nxt);
        if (hc >= 0) chk($sformatf("high_cycles c=%0d", c), hc_n, hc);
        if (take) void'(req_q.pop_front());
        exp_ready     = nxt;
        io_duty_valid = 1'b0;
    endtask

    // Full 0..31 period with a given effective duty and expected report.
    task automatic run_period(input int duty, input int prev_hc, input int enq_at,
                              input int v1, input int v2);
        for (int c = 0; c < 32; c++) begin
            if (c == enq_at) begin
                req_q.push_back(v1);
                if (v2 >= 0) req_q.push_back(v2);
            end
            step(c, c == 0, c < duty, (c == 0) ? prev_hc : -1);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " pwm"}, pwm_n, 0);
        chk({tag, " pwm_inv"}, pwm_i, 1);
        chk({tag, " ready"}, ready_n, 1);
        chk({tag, " high_cycles"}, hc_n, 0);
        chk({tag, " stat_valid"}, sv_n, 0);
        chk({tag, " boundary"}, bnd_n, 0);
    endtask

    initial begin
        reset         = 1'b1;
        io_cnt        = 5'd7;
        io_duty       = '0;
        io_duty_valid = 1'b0;
        exp_ready     = 1'b1;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        reset = 1'b0;

        // Basic compare: load 8 mid-period; takes effect next period
        run_period(0, 0, 5, 8, -1);
        run_period(8, 0, -1, 0, -1);
        // Back-pressure: 4 then 20 queued back to back
        run_period(8, 8, 10, 4, 20);
        run_period(4, 8, -1, 0, -1);
        run_period(20, 4, -1, 0, -1);
        // Same-cycle load on a boundary with empty buffer
        run_period(20, 20, 0, 10, -1);
        run_period(10, 20, -1, 0, -1);
        run_period(10, 10, 5, 31, -1);
        run_period(31, 10, -1, 0, -1);

        // Turnaround boundaries with active = 31
        step(0, 1'b1, 1'b1, 31);
        for (int c = 1; c <= 28; c++) step(c, 1'b0, 1'b1, -1);
        step(29, 1'b0, 1'b1, -1);
        step(30, 1'b0, 1'b1, -1);
        step(31, 1'b0, 1'b0, -1);
        step(30, 1'b1, 1'b1, 31);
        step(31, 1'b0, 1'b0, -1);
        step(30, 1'b1, 1'b1, 1);
        step(31, 1'b0, 1'b0, -1);
        step(30, 1'b1, 1'b1, 1);

        // Duty 0 extreme (inverted instance must stay high)
        run_period(31, 1, 3, 0, -1);
        run_period(0, 31, -1, 0, -1);
        run_period(0, 0, -1, 0, -1);

        // Reset mid-period with a buffered duty of 12
        for (int c = 0; c < 15; c++) begin
            if (c == 5) req_q.push_back(12);
            step(c, c == 0, 1'b0, (c == 0) ? 0 : -1);
        end
        chk("pending before reset", ready_n, 0);
        reset  = 1'b1;
        io_cnt = 5'd15;
        @(posedge clk);
        #1;
        chk_reset_outputs("mid reset");
        reset     = 1'b0;
        exp_ready = 1'b1;
        run_period(0, 0, -1, 0, -1);
        run_period(0, 0, -1, 0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
